// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_add_multiplier
//  Purpose  : Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with
//             optional two's-complement mode and valid/ready handshakes on
//             both the operand and product sides. One partial product is
//             accumulated per cycle; latency is fixed at WIDTH+1 cycles.
//  Revision : 1.0  initial release
// ============================================================================
module seq_shift_add_multiplier #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [WIDTH-1:0]   in_q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;

  logic                 signed_mode;
  logic [WIDTH-1:0]     m_mag;
  logic [WIDTH-1:0]     q_mag;
  logic                 any_zero;
  logic [2*WIDTH-1:0]   acc_sum;

  // Operand conditioning: magnitudes and zero detection for the accept edge,
  // plus the partial-product sum for the current iteration.
  always_comb begin
    signed_mode = SIGNED_EN & in_signed;
    // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude
    m_mag       = (signed_mode && in_m[WIDTH-1]) ? (-in_m) : in_m;
    q_mag       = (signed_mode && in_q[WIDTH-1]) ? (-in_q) : in_q;
    any_zero    = (in_m == '0) || (in_q == '0);
    acc_sum     = q_q[0] ? (acc_q + m_q) : acc_q;
  end

  // Next-state and datapath update for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          m_d     = {{WIDTH{1'b0}}, m_mag};
          q_d     = q_mag;
          acc_d   = '0;
          cnt_d   = '0;
          // a zero operand never produces a negated result
          neg_d   = signed_mode & (in_m[WIDTH-1] ^ in_q[WIDTH-1]) & ~any_zero;
        end
      end
      BUSY: begin
        acc_d = acc_sum;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          p_d     = neg_q ? (-acc_sum) : acc_sum;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = p_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_shift_add_multiplier
//  Purpose  : Self-checking bench for seq_shift_add_multiplier. A signed-mode
//             and an unsigned-only build share all inputs; expected products
//             are queued at accept time and compared as results are taken.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_shift_add_multiplier;

  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_signed;
  logic [W-1:0]     in_m;
  logic [W-1:0]     in_q;
  logic             out_ready;

  logic             in_ready_s, out_valid_s, busy_s;
  logic [2*W-1:0]   out_p_s;
  logic             in_ready_u, out_valid_u, busy_u;
  logic [2*W-1:0]   out_p_u;

  int               n_checks = 0;
  int               n_errors = 0;
  int               n_sent   = 0;
  int               n_got_s  = 0;
  int               n_got_u  = 0;
  int               ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  logic [2*W-1:0]   exp_s_q[$];
  logic [2*W-1:0]   exp_u_q[$];

  seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_signed (in_signed),
    .in_m      (in_m),
    .in_q      (in_q),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_p     (out_p_s),
    .busy      (busy_s)
  );

  seq_shift_add_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_u),
    .in_signed (in_signed),
    .in_m      (in_m),
    .in_q      (in_q),
    .out_valid (out_valid_u),
    .out_ready (out_ready),
    .out_p     (out_p_u),
    .busy      (busy_u)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q,
                                           input logic s, input bit sen);
    int a, b;
    if (sen && s) begin
      a = $signed(m);
      b = $signed(q);
    end else begin
      a = int'(m);
      b = int'(q);
    end
    return (2*W)'(a * b);
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one operand pair, wait for acceptance, queue expected products.
  task automatic send(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
    int guard = 0;
    while (!in_ready_s && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready_s) begin
      check_val("ready_timeout", 16'(in_ready_s), 16'd1);
      return;
    end
    in_valid  = 1'b1;
    in_m      = m;
    in_q      = q;
    in_signed = s;
    exp_s_q.push_back(model(m, q, s, 1'b1));
    exp_u_q.push_back(model(m, q, s, 1'b0));
    n_sent++;
    tick();
    in_valid  = 1'b0;
    in_m      = W'($urandom);
    in_q      = W'($urandom);
    in_signed = 1'($urandom);
  endtask

  task automatic wait_valid(input string tag);
    int guard = 0;
    while (!out_valid_s && guard < 50) begin
      tick();
      guard++;
    end
    check_val(tag, 16'(out_valid_s), 16'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_s_q.size() != 0 || exp_u_q.size() != 0 || !in_ready_s) && guard < 2000) begin
      tick();
      guard++;
    end
    check_val("drain", 16'(exp_s_q.size() + exp_u_q.size()), 16'd0);
  endtask

  // Output side: choose out_ready for the coming edge, then score any handshake.
  always @(negedge clk) begin
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst && out_ready) begin
      if (out_valid_s) begin
        if (exp_s_q.size() == 0) check_val("s_unexpected", 16'd1, 16'd0);
        else                     check_val("s_prod", 16'(out_p_s), 16'(exp_s_q.pop_front()));
        n_got_s++;
      end
      if (out_valid_u) begin
        if (exp_u_q.size() == 0) check_val("u_unexpected", 16'd1, 16'd0);
        else                     check_val("u_prod", 16'(out_p_u), 16'(exp_u_q.pop_front()));
        n_got_u++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_m      = '0;
    in_q      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check_val("rst_in_ready",  16'(in_ready_s),  16'd1);
    check_val("rst_out_valid", 16'(out_valid_s), 16'd0);
    check_val("rst_busy",      16'(busy_s),      16'd0);
    check_val("rst_out_p",     16'(out_p_s),     16'd0);
    check_val("rst_u_in_ready",16'(in_ready_u),  16'd1);
    rst = 1'b0;
    tick();

    // Fixed latency: accept in N, busy N+1..N+5, out_valid first in N+5.
    check_val("lat_idle_busy", 16'(busy_s), 16'd0);
    send(4'hF, 4'hF, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      check_val("lat_busy",      16'(busy_s),      16'd1);
      check_val("lat_out_valid", 16'(out_valid_s), 16'd0);
      tick();
    end
    check_val("lat_valid_n5", 16'(out_valid_s), 16'd1);
    check_val("lat_busy_n5",  16'(busy_s),      16'd1);
    check_val("lat_prod_e1",  16'(out_p_s),     16'h00E1);
    tick();
    check_val("lat_back_idle", 16'(in_ready_s), 16'd1);
    check_val("lat_busy_n6",   16'(busy_s),     16'd0);

    // Signed corner products and the same bits taken as unsigned.
    send(4'h8, 4'h8, 1'b1);
    send(4'h3, 4'hB, 1'b1);
    send(4'h3, 4'hB, 1'b0);
    drain();

    // Output stall: product and flags hold while the producer wiggles inputs.
    ready_mode = 0;
    send(4'h5, 4'h6, 1'b1);
    wait_valid("stall_valid");
    for (int k = 0; k < 10; k++) begin
      in_valid = ~in_valid;
      in_m     = W'($urandom);
      in_q     = W'($urandom);
      tick();
      check_val("stall_out_p",     16'(out_p_s),     16'h001E);
      check_val("stall_out_valid", 16'(out_valid_s), 16'd1);
      check_val("stall_in_ready",  16'(in_ready_s),  16'd0);
    end
    in_valid   = 1'b0;
    ready_mode = 1;
    check_val("release_in_ready_same", 16'(in_ready_s), 16'd0);
    tick();
    check_val("release_in_ready_next", 16'(in_ready_s),  16'd1);
    check_val("release_out_valid",     16'(out_valid_s), 16'd0);
    send(4'h2, 4'h3, 1'b0);
    drain();

    // Reset during iteration 2 aborts immediately.
    send(4'hA, 4'h3, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_val("abort_out_valid", 16'(out_valid_s), 16'd0);
    check_val("abort_busy",      16'(busy_s),      16'd0);
    check_val("abort_in_ready",  16'(in_ready_s),  16'd1);
    n_sent -= exp_s_q.size();
    exp_s_q.delete();
    exp_u_q.delete();
    tick();
    rst = 1'b0;
    tick();
    send(4'h7, 4'h9, 1'b0);
    for (int k = 1; k <= 4; k++) tick();
    check_val("post_abort_valid", 16'(out_valid_s), 16'd1);
    check_val("post_abort_prod",  16'(out_p_s),     16'h003F);
    drain();

    // Zero operands in signed mode; all-ones with mode bit set.
    send(4'h0, 4'h8, 1'b1);
    send(4'h8, 4'h0, 1'b1);
    send(4'hF, 4'hF, 1'b1);
    drain();

    // Every operand pair in both modes under random output stalls.
    ready_mode = 2;
    for (int s = 0; s < 2; s++)
      for (int m = 0; m < 16; m++)
        for (int q = 0; q < 16; q++)
          send(W'(m), W'(q), 1'(s));
    drain();
    ready_mode = 1;

    check_val("count_s", 16'(n_got_s), 16'(n_sent));
    check_val("count_u", 16'(n_got_u), 16'(n_sent));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
